// File: rtl/phy_tx_lanes_if.sv
// Word-input handshake and per-lane symbol outputs of the multi-lane PHY transmit path.
// The master side drives words and the lane count; the slave side is the transmitter.
interface phy_tx_lanes_if #(
  parameter int LANES  = 4,
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
);
  logic [WORD_W-1:0]       data_in;
  logic                    valid_in;
  logic                    ready_out;
  logic [$clog2(LANES):0]  active_lanes;
  logic [LANES*BYTE_W-1:0] data_out;
  logic [LANES-1:0]        valid_out;
  logic                    idle_out;

  modport master (
    output data_in, valid_in, active_lanes,
    input  ready_out, data_out, valid_out, idle_out
  );

  modport slave (
    input  data_in, valid_in, active_lanes,
    output ready_out, data_out, valid_out, idle_out
  );
endinterface

// File: rtl/phy_tx_lanes.sv
// Stripes input words round-robin over a run-time lane count; each lane buffers words
// in a small FIFO and serialises them MSB-first, one symbol per clock, gap-free.
module phy_tx_lanes #(
  parameter int                LANES    = 4,
  parameter int                WORD_W   = 32,
  parameter int                BYTE_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [BYTE_W-1:0] IDLE_SYM = 8'hBC
) (
  input  logic          clk_32f,
  input  logic          reset,
  phy_tx_lanes_if.slave io_bus
);
  localparam int            LW        = $clog2(LANES) + 1;
  localparam int            PW        = $clog2(DEPTH) + 1;
  localparam int            NB        = WORD_W / BYTE_W;
  localparam int            KW        = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] K_LAST    = KW'(NB - 1);
  localparam logic [LW-1:0] LANES_MAX = LW'(LANES);

  typedef enum logic {S_IDLE, S_SEND} ser_state_t;

  logic [LW-1:0]           r_lanes;
  logic [LW-1:0]           r_wr_lane;
  logic [LW-1:0]           w_wr_inc;
  logic [LW-1:0]           w_req_lanes;
  logic [LANES-1:0]        w_full;
  logic [LANES-1:0]        w_empty;
  logic [LANES-1:0]        w_busy;
  logic [LANES-1:0]        w_push;
  logic [LANES-1:0]        w_valid_out;
  logic [LANES*BYTE_W-1:0] w_data_out;
  logic                    w_full_sel;
  logic                    w_ready;
  logic                    w_xfer;
  logic                    w_idle;

  // Out-of-range requests fall back to the full lane count.
  assign w_req_lanes = (io_bus.active_lanes == '0 || io_bus.active_lanes > LANES_MAX)
                       ? LANES_MAX : io_bus.active_lanes;

  always_comb begin
    w_full_sel = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (r_wr_lane == LW'(i)) w_full_sel = w_full[i];
    end
  end

  assign w_ready  = !reset && !w_full_sel;
  assign w_xfer   = io_bus.valid_in && w_ready;
  assign w_idle   = (&w_empty) && !(|w_busy);
  assign w_wr_inc = r_wr_lane + 1'b1;

  // Lane count only changes while nothing is in flight, so striping never splits mid-mode.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_lanes   <= w_req_lanes;
      r_wr_lane <= '0;
    end else if (w_xfer) begin
      r_wr_lane <= (w_wr_inc >= r_lanes) ? '0 : w_wr_inc;
    end else if (w_idle) begin
      r_lanes   <= w_req_lanes;
      r_wr_lane <= '0;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [WORD_W-1:0] w_rd_word;
    logic              w_pop;
    ser_state_t        r_state;
    logic [KW-1:0]     r_k;
    logic [WORD_W-1:0] r_shift;
    logic [BYTE_W-1:0] r_sym;
    logic              r_vld;

    assign w_empty[gi] = (r_wptr == r_rptr);
    assign w_full[gi]  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                         (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
    assign w_push[gi]  = w_xfer && (r_wr_lane == LW'(gi));
    assign w_rd_word   = r_mem[r_rptr[PW-2:0]];
    assign w_pop       = !w_empty[gi] && (r_state == S_IDLE || r_k == K_LAST);
    assign w_busy[gi]  = (r_state == S_SEND) && (r_k != K_LAST);

    always_ff @(posedge clk_32f) begin
      if (w_push[gi]) r_mem[r_wptr[PW-2:0]] <= io_bus.data_in;
    end

    always_ff @(posedge clk_32f) begin
      if (reset) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push[gi]) r_wptr <= r_wptr + 1'b1;
        if (w_pop)      r_rptr <= r_rptr + 1'b1;
      end
    end

    // r_shift holds the bytes of the current word still to be presented.
    always_ff @(posedge clk_32f) begin
      if (reset) begin
        r_state <= S_IDLE;
        r_k     <= '0;
        r_shift <= '0;
        r_sym   <= IDLE_SYM;
        r_vld   <= 1'b0;
      end else if (w_pop) begin
        r_state <= S_SEND;
        r_k     <= '0;
        r_sym   <= w_rd_word[WORD_W-1 -: BYTE_W];
        r_shift <= w_rd_word << BYTE_W;
        r_vld   <= 1'b1;
      end else if (r_state == S_SEND && r_k != K_LAST) begin
        r_k     <= r_k + 1'b1;
        r_sym   <= r_shift[WORD_W-1 -: BYTE_W];
        r_shift <= r_shift << BYTE_W;
        r_vld   <= 1'b1;
      end else begin
        r_state <= S_IDLE;
        r_k     <= '0;
        r_sym   <= IDLE_SYM;
        r_vld   <= 1'b0;
      end
    end

    assign w_data_out[gi*BYTE_W +: BYTE_W] = r_sym;
    assign w_valid_out[gi]                 = r_vld;
  end

  assign io_bus.ready_out = w_ready;
  assign io_bus.idle_out  = w_idle;
  assign io_bus.data_out  = w_data_out;
  assign io_bus.valid_out = w_valid_out;
endmodule

// File: tb/tb_phy_tx_lanes.sv
// Directed and random stimulus for phy_tx_lanes, checked every cycle against a queue-based
// model of per-lane word buffers and pending symbols.
module tb_phy_tx_lanes;
  localparam int                LANES  = 4;
  localparam int                WORD_W = 32;
  localparam int                BYTE_W = 8;
  localparam int                DEPTH  = 2;
  localparam int                NB     = WORD_W / BYTE_W;
  localparam int                LW     = $clog2(LANES) + 1;
  localparam logic [BYTE_W-1:0] IDLE   = 8'hBC;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  phy_tx_lanes_if #(.LANES(LANES), .WORD_W(WORD_W), .BYTE_W(BYTE_W)) bus ();

  phy_tx_lanes #(
    .LANES(LANES), .WORD_W(WORD_W), .BYTE_W(BYTE_W), .DEPTH(DEPTH), .IDLE_SYM(IDLE)
  ) dut (
    .clk_32f(clk),
    .reset  (reset),
    .io_bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [WORD_W-1:0] m_fifo [LANES][$];
  logic [BYTE_W-1:0] m_pend [LANES][$];
  logic [BYTE_W-1:0] m_sym  [LANES];
  logic              m_vld  [LANES];
  int                m_lanes = LANES;
  int                m_wr    = 0;
  bit                m_init  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int san(input int a);
    return (a == 0 || a > LANES) ? LANES : a;
  endfunction

  // One clock: drive inputs, check ready/idle before the edge, advance model, check lanes after.
  task automatic step(input logic rst, input logic vin, input logic [WORD_W-1:0] din,
                      input logic [LW-1:0] act, output bit xfer, output logic rdy);
    bit                    exp_ready, exp_idle;
    logic [WORD_W-1:0]     w;
    logic [LANES*BYTE_W-1:0] ed;
    logic [LANES-1:0]      ev;
    @(negedge clk);
    reset            = rst;
    bus.valid_in     = vin;
    bus.data_in      = din;
    bus.active_lanes = act;
    #1;
    rdy      = bus.ready_out;
    exp_idle = 1'b1;
    for (int l = 0; l < LANES; l++)
      if (m_fifo[l].size() != 0 || m_pend[l].size() != 0) exp_idle = 1'b0;
    exp_ready = !rst && (m_fifo[m_wr].size() < DEPTH);
    if (m_init) begin
      chk("ready_out", rdy, exp_ready);
      chk("idle_out", bus.idle_out, exp_idle);
    end
    xfer = vin && exp_ready && m_init;
    @(posedge clk);
    if (rst) begin
      for (int l = 0; l < LANES; l++) begin
        m_fifo[l].delete();
        m_pend[l].delete();
        m_sym[l] = IDLE;
        m_vld[l] = 1'b0;
      end
      m_lanes = san(int'(act));
      m_wr    = 0;
      m_init  = 1'b1;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (m_pend[l].size() != 0) begin
          m_sym[l] = m_pend[l].pop_front();
          m_vld[l] = 1'b1;
        end else if (m_fifo[l].size() != 0) begin
          w = m_fifo[l].pop_front();
          m_sym[l] = w[WORD_W-1 -: BYTE_W];
          m_vld[l] = 1'b1;
          for (int k = 1; k < NB; k++) m_pend[l].push_back(w[WORD_W-1-k*BYTE_W -: BYTE_W]);
        end else begin
          m_sym[l] = IDLE;
          m_vld[l] = 1'b0;
        end
      end
      if (xfer) begin
        $display("[TB] word %h -> lane %0d", din, m_wr);
        m_fifo[m_wr].push_back(din);
        m_wr = (m_wr + 1) % m_lanes;
      end else if (exp_idle) begin
        m_lanes = san(int'(act));
        m_wr    = 0;
      end
    end
    #1;
    for (int l = 0; l < LANES; l++) begin
      ed[l*BYTE_W +: BYTE_W] = m_sym[l];
      ev[l]                  = m_vld[l];
    end
    chk("data_out", bus.data_out, ed);
    chk("valid_out", bus.valid_out, ev);
  endtask

  initial begin
    bit                x;
    logic              r;
    logic [WORD_W-1:0] sw;
    logic [BYTE_W-1:0] got[$];
    int                idx, stalls, cyc, c0, c2, c3, c_other;
    logic              rr, rv;
    logic [LW-1:0]     ra;

    reset = 1'b1;
    bus.valid_in = 1'b1;
    bus.data_in = '0;
    bus.active_lanes = 3'd4;

    // Reset held three cycles with valid high.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'h12345678, 3'd4, x, r);
      chk("rst_ready", r, 1'b0);
      chk("rst_data", bus.data_out, 32'hBCBCBCBC);
      chk("rst_valid", bus.valid_out, 4'b0000);
      chk("rst_idle", bus.idle_out, 1'b1);
    end

    // Single word on a two-lane configuration.
    step(1'b0, 1'b0, '0, 3'd2, x, r);
    sw = 32'hAABBCCDD;
    step(1'b0, 1'b1, sw, 3'd2, x, r);
    for (int k = 0; k < NB; k++) begin
      step(1'b0, 1'b0, '0, 3'd2, x, r);
      chk("single_byte", bus.data_out[7:0], sw[31-8*k -: 8]);
      chk("single_valid", bus.valid_out, 4'b0001);
      chk("single_others", bus.data_out[31:8], 24'hBCBCBC);
      if (k == 0) chk("single_busy", bus.idle_out, 1'b0);
    end
    chk("single_idle_back", bus.idle_out, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 3'd4, x, r);

    // Striping over four lanes: each lane starts one cycle after its neighbour.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 32'h01010101 * i, 3'd4, x, r);
      chk("stripe_ready", r, 1'b1);
      chk("stripe_skew", bus.valid_out, (i < 4) ? ((4'b0001 << i) - 1) : 4'b1111);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 3'd4, x, r);

    // Backpressure on a single lane with a two-word FIFO.
    step(1'b0, 1'b0, '0, 3'd1, x, r);
    idx = 0; stalls = 0; cyc = 0;
    while (idx < 6 && cyc < 80) begin
      sw = {8'(16 + 4*idx), 8'(17 + 4*idx), 8'(18 + 4*idx), 8'(19 + 4*idx)};
      step(1'b0, 1'b1, sw, 3'd1, x, r);
      if (x) idx++;
      if (!r) stalls++;
      if (bus.valid_out[0]) got.push_back(bus.data_out[7:0]);
      cyc++;
    end
    chk("bp_all_accepted", idx, 6);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, '0, 3'd1, x, r);
      if (bus.valid_out[0]) got.push_back(bus.data_out[7:0]);
    end
    chk("bp_stalled", stalls > 0, 1'b1);
    chk("bp_byte_count", got.size(), 24);
    for (int j = 0; j < got.size() && j < 24; j++) chk("bp_byte_order", got[j], 8'(16 + j));

    // Lane-count change during a burst waits for idle.
    step(1'b0, 1'b0, '0, 3'd4, x, r);
    c3 = 0; c2 = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 32'hC0C0C0C0 + i, (i < 2) ? 3'd4 : 3'd1, x, r);
      if (bus.valid_out[2]) c2++;
      if (bus.valid_out[3]) c3++;
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, '0, 3'd1, x, r);
      if (bus.valid_out[2]) c2++;
      if (bus.valid_out[3]) c3++;
    end
    chk("defer_lane2_used", c2, 4);
    chk("defer_lane3_used", c3, 4);
    c0 = 0; c_other = 0;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 32'hE0E1E2E3 + i, 3'd1, x, r);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0, 3'd1, x, r);
      if (bus.valid_out[0]) c0++;
      c_other += int'(bus.valid_out[1]) + int'(bus.valid_out[2]) + int'(bus.valid_out[3]);
    end
    chk("defer_lane0_bytes", c0 + 1, 8);
    chk("defer_other_lanes", c_other, 0);

    // A lane count of zero behaves as the full lane count.
    step(1'b0, 1'b0, '0, 3'd0, x, r);
    c3 = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h55555555 + i, 3'd0, x, r);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0, 3'd0, x, r);
      if (bus.valid_out[3]) c3++;
    end
    chk("act0_lane3", c3, 4);

    // Reset while lane 0 is mid-word with two words queued.
    step(1'b0, 1'b0, '0, 3'd1, x, r);
    step(1'b0, 1'b1, 32'hA0A1A2A3, 3'd1, x, r);
    step(1'b0, 1'b1, 32'hB0B1B2B3, 3'd1, x, r);
    step(1'b0, 1'b1, 32'hC0C1C2C3, 3'd1, x, r);
    chk("midrst_before", bus.data_out[7:0], 8'hA1);
    step(1'b1, 1'b0, '0, 3'd1, x, r);
    chk("midrst_sym", bus.data_out, 32'hBCBCBCBC);
    chk("midrst_valid", bus.valid_out, 4'b0000);
    c_other = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0, 3'd1, x, r);
      if (bus.valid_out != 0) c_other++;
    end
    chk("midrst_no_leftover", c_other, 0);

    // Random traffic, lane-count requests and occasional resets.
    ra = 3'd4;
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      rv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) ra = LW'($urandom_range(0, 7));
      step(rr, rv, $urandom, ra, x, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
